// File: rtl/cvt_issue_ctrl.sv
// cvt_issue_ctrl: front-end dispatcher for the float/int converter unit.
//
// Tagged convert requests are queued in a DEPTH-entry FIFO. They are issued to
// the converter one at a time. Each result is returned, with its tag, to
// register-file writeback over a valid/ready handshake.
//
// Build option: define CVT_TIMEOUT_EN to abort a conversion that shows no
// cv_done after TIMEOUT WAIT cycles. The aborted op is reported with
// wb_err = 1 and wb_data = 0. Without the macro, WAIT holds until cv_done and
// wb_err is tied to 0.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (req_ready = FIFO not full)
//   req_mode        0 = float->int, 1 = int->float
//   req_data/tag    operand and destination register tag
//   cv_en           converter enable, high through ISSUE and WAIT
//   cv_start        one-cycle start pulse (ISSUE)
//   cv_mode/data    operation held from issue until the next pop
//   cv_done         converter done pulse (only honoured in WAIT)
//   cv_result       converter result, valid with cv_done
//   wb_valid/ready  writeback handshake
//   wb_tag/data     result tag and data, stable while wb_valid is high
//   wb_err          timeout flag qualifying wb_valid
//   busy            FIFO non-empty or an op in flight
module cvt_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [31:0]      req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic             cv_en,
  output logic             cv_start,
  output logic             cv_mode,
  output logic [31:0]      cv_data,
  input  logic             cv_done,
  input  logic [31:0]      cv_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             wb_err,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic             mode;
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t        state;
  req_t          mem [DEPTH];
  req_t          cur;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          active_nxt;

`ifdef CVT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  assign wb_err = 1'b0;
`endif

  // An out-of-range TIMEOUT shows up as this named block in the elaborated hierarchy.
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_out_of_range
  end

  // FIFO handshake and occupancy; no bypass, so a pop only sees stored entries.
  always_comb begin
    push      = req_valid && req_ready;
    pop       = (state == IDLE) && (count != '0);
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Whether an op will be in flight after this edge (feeds the registered busy).
  always_comb begin
    active_nxt = 1'b0;
    case (state)
      IDLE:    active_nxt = pop;
      ISSUE:   active_nxt = 1'b1;
      WAIT:    active_nxt = 1'b1;
      WB:      active_nxt = !wb_ready;
      default: active_nxt = 1'b0;
    endcase
  end

  // Request storage: payload only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{mode: req_mode, data: req_data, tag: req_tag};
    end
  end

  // FIFO pointers, count and the status outputs derived from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      req_ready <= (count_nxt != CW'(DEPTH));
      busy      <= (count_nxt != '0) || active_nxt;
    end
  end

  // Issue FSM: IDLE pops, ISSUE pulses start, WAIT collects the result, WB hands it off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      cv_en    <= 1'b0;
      cv_start <= 1'b0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
`ifdef CVT_TIMEOUT_EN
      wb_err   <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      cv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur      <= mem[rd_ptr];
            cv_en    <= 1'b1;
            cv_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CVT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (cv_done) begin
            cv_en    <= 1'b0;
            wb_valid <= 1'b1;
            wb_tag   <= cur.tag;
            wb_data  <= cv_result;
            state    <= WB;
`ifdef CVT_TIMEOUT_EN
          end else if (wait_cnt == TO_LAST) begin
            // Abandon the op; any later cv_done lands outside WAIT and is dropped.
            cv_en    <= 1'b0;
            wb_valid <= 1'b1;
            wb_tag   <= cur.tag;
            wb_data  <= '0;
            wb_err   <= 1'b1;
            state    <= WB;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
`ifdef CVT_TIMEOUT_EN
            wb_err   <= 1'b0;
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cv_mode = cur.mode;
  assign cv_data = cur.data;

endmodule

// File: tb/tb_cvt_issue_ctrl.sv
// Directed bench for cvt_issue_ctrl with a fixed-latency converter model.
module tb_cvt_issue_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned TIMEOUT = 31;
  localparam int          LAT     = 6;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [31:0]      req_data;
  logic [TAG_W-1:0] req_tag;
  logic             cv_en;
  logic             cv_start;
  logic             cv_mode;
  logic [31:0]      cv_data;
  logic             cv_done;
  logic [31:0]      cv_result;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_err;
  logic             busy;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int last_start = -1;
  int min_gap   = 100000;
  int wb_rise   = 0;
  logic wb_prev = 1'b0;
  bit model_off = 1'b0;

  cvt_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_tag(req_tag),
    .cv_en(cv_en), .cv_start(cv_start), .cv_mode(cv_mode), .cv_data(cv_data),
    .cv_done(cv_done), .cv_result(cv_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference converter behaviour used both by the model and for expected data.
  function automatic logic [31:0] conv(input logic m, input logic [31:0] d);
    if (!m && d == 32'h40490FDB) return 32'h3;
    return m ? d + 32'h100 : d >> 4;
  endfunction

  // Converter model: done pulse in the LAT-th cycle after start is seen.
  initial begin : conv_model
    logic [31:0] d;
    logic        m;
    cv_done   = 1'b0;
    cv_result = '0;
    forever begin
      @(posedge clk);
      if (cv_start === 1'b1 && !model_off) begin
        d = cv_data;
        m = cv_mode;
        for (int i = 0; i < LAT; i++) begin
          @(negedge clk);
          if (cv_en === 1'b1) chk("cv_data_stable", cv_data, d);
        end
        cv_done   = 1'b1;
        cv_result = conv(m, d);
        @(negedge clk);
        cv_done   = 1'b0;
        cv_result = '0;
      end
    end
  end

  // Start pulse / writeback event monitor.
  always @(posedge clk) begin
    cyc++;
    if (cv_start === 1'b1) begin
      if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
      last_start = cyc;
      start_cnt++;
    end
    if (wb_valid === 1'b1 && wb_prev !== 1'b1) wb_rise++;
    wb_prev = wb_valid;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_req(input logic m, input logic [31:0] d, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_mode  = m;
    req_data  = d;
    req_tag   = t;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_seen", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int max, output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wb_valid_seen", 32'(wb_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, "_cv_en"},     32'(cv_en),     32'd0);
    chk({pfx, "_cv_start"},  32'(cv_start),  32'd0);
    chk({pfx, "_cv_mode"},   32'(cv_mode),   32'd0);
    chk({pfx, "_cv_data"},   cv_data,        32'd0);
    chk({pfx, "_wb_valid"},  32'(wb_valid),  32'd0);
    chk({pfx, "_wb_err"},    32'(wb_err),    32'd0);
    chk({pfx, "_wb_data"},   wb_data,        32'd0);
    chk({pfx, "_wb_tag"},    32'(wb_tag),    32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin : main
    int n;
    int s0;
    int r0;
    int unstable;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_data  = '0;
    req_tag   = '0;
    wb_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single F2I conversion
    push_req(1'b0, 32'h40490FDB, 5'd7);
    chk("t1_start_before_pop", 32'(cv_start), 32'd0);
    chk("t1_busy_queued", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_start_pulse", 32'(cv_start), 32'd1);
    chk("t1_en_issue", 32'(cv_en), 32'd1);
    chk("t1_mode", 32'(cv_mode), 32'd0);
    chk("t1_data", cv_data, 32'h40490FDB);
    @(negedge clk);
    chk("t1_start_one_cycle", 32'(cv_start), 32'd0);
    chk("t1_en_wait", 32'(cv_en), 32'd1);
    wait_wb(50, n);
    chk("t1_done_to_wb", 32'(n), 32'(LAT));
    chk("t1_wb_tag", 32'(wb_tag), 32'd7);
    chk("t1_wb_data", wb_data, 32'h3);
    chk("t1_wb_err", 32'(wb_err), 32'd0);
    chk("t1_en_off_wb", 32'(cv_en), 32'd0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("t1_wb_drop", 32'(wb_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Queue fill: op 1 issues at once, ops 2..5 fill the FIFO
    for (int k = 1; k <= 5; k++) push_req(1'b1, 32'h1000 * k, TAG_W'(k));
    chk("t2_full_ready_low", 32'(req_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);

    // Backpressure on the first result
    wait_wb(50, n);
    s0 = start_cnt;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_tag !== TAG_W'(1) || wb_data !== conv(1'b1, 32'h1000))
        unstable++;
    end
    chk("t3_wb_hold_stable", 32'(unstable), 32'd0);
    chk("t3_no_start_in_wb", 32'(start_cnt), 32'(s0));
    chk("t3_still_full", 32'(req_ready), 32'd0);

    // Drain in order
    for (int k = 1; k <= 5; k++) begin
      wait_wb(50, n);
      chk($sformatf("t2_tag_%0d", k), 32'(wb_tag), 32'(k));
      chk($sformatf("t2_data_%0d", k), wb_data, conv(1'b1, 32'h1000 * k));
      chk($sformatf("t2_err_%0d", k), 32'(wb_err), 32'd0);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
    end
    @(negedge clk);
    chk("t2_drained_busy", 32'(busy), 32'd0);
    chk("t2_start_count", 32'(start_cnt), 32'd6);
    chk("t2_wb_count", 32'(wb_rise), 32'd6);
    chk("t2_min_issue_gap_ok", 32'(min_gap >= LAT + 3), 32'd1);

    // Reset while in WAIT with two ops queued
    push_req(1'b1, 32'hA, 5'd10);
    push_req(1'b1, 32'hB, 5'd11);
    push_req(1'b1, 32'hC, 5'd12);
    @(negedge clk);
    chk("t4_in_wait_en", 32'(cv_en), 32'd1);
    chk("t4_in_wait_mode", 32'(cv_mode), 32'd1);
    chk("t4_in_wait_data", cv_data, 32'hA);
    chk("t4_queued_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t4_rst");
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    r0 = wb_rise;
    // the model's pending done pulse lands while IDLE and must be dropped
    repeat (30) @(negedge clk);
    chk("t4_no_start_after", 32'(start_cnt), 32'(s0));
    chk("t4_no_wb_after", 32'(wb_rise), 32'(r0));
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // Spurious done while IDLE and empty
    cv_done   = 1'b1;
    cv_result = 32'hDEAD_BEEF;
    @(negedge clk);
    cv_done   = 1'b0;
    cv_result = '0;
    @(negedge clk);
    chk("t5_spur_wb_valid", 32'(wb_valid), 32'd0);
    chk("t5_spur_busy", 32'(busy), 32'd0);
    chk("t5_spur_cv_en", 32'(cv_en), 32'd0);

    // Converter that never answers
    model_off = 1'b1;
    push_req(1'b0, 32'h1234, 5'd20);
    @(negedge clk);
    chk("t6_start", 32'(cv_start), 32'd1);
`ifdef CVT_TIMEOUT_EN
    wait_wb(100, n);
    chk("t6_timeout_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("t6_to_data", wb_data, 32'd0);
    chk("t6_to_err", 32'(wb_err), 32'd1);
    chk("t6_to_tag", 32'(wb_tag), 32'd20);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("t6_err_clear", 32'(wb_err), 32'd0);
    chk("t6_wb_drop", 32'(wb_valid), 32'd0);
    cv_done = 1'b1;
    @(negedge clk);
    cv_done = 1'b0;
    @(negedge clk);
    chk("t6_stray_done_wb", 32'(wb_valid), 32'd0);
    chk("t6_stray_done_busy", 32'(busy), 32'd0);
`else
    repeat (60) @(negedge clk);
    chk("t6_hold_wb_valid", 32'(wb_valid), 32'd0);
    chk("t6_hold_busy", 32'(busy), 32'd1);
    chk("t6_hold_en", 32'(cv_en), 32'd1);
    chk("t6_hold_err", 32'(wb_err), 32'd0);
    cv_done   = 1'b1;
    cv_result = 32'h55;
    @(negedge clk);
    cv_done   = 1'b0;
    cv_result = '0;
    chk("t6_late_wb_valid", 32'(wb_valid), 32'd1);
    chk("t6_late_data", wb_data, 32'h55);
    chk("t6_late_tag", 32'(wb_tag), 32'd20);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("t6_done_busy", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
